sdram_port_arbit: RTL and testbench
===================================

# sdram_port_arbit

Parametrised multi-port front end for the SDRAM controller: arbitrates `NUM_PORTS` independent read/write requesters onto the controller's single write port and single read port. Grants are round-robin per burst. The block muxes address, burst length and write data from the granted port, and routes the acknowledge back to that port. It sits between the frame/FIFO clients and the SDRAM controller top, and replaces the single-client wiring used until now.

## Interface
Parameters:
- `NUM_PORTS`, 4, number of client ports, 1..8
- `ADDR_W`, 21, SDRAM word address width
- `DATA_W`, 32, data width
- `BLEN_W`, 9, burst-length width
- `TIMEOUT_CYC`, 1024, watchdog limit in cycles; used only with the macro in Configuration

Ports:
- `sys_clk` in 1: system clock (100 MHz)
- `sys_rst_n` in 1: asynchronous active-low reset
- `port_wr_req` in NUM_PORTS: per-port write request
- `port_wr_addr` in NUM_PORTS*ADDR_W: packed write addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- `port_wr_len` in NUM_PORTS*BLEN_W: packed write burst lengths
- `port_wr_data` in NUM_PORTS*DATA_W: packed write data
- `port_wr_ack` out NUM_PORTS: per-port write acknowledge, one-hot or zero
- `port_rd_req` in NUM_PORTS: per-port read request
- `port_rd_addr` in NUM_PORTS*ADDR_W: packed read addresses
- `port_rd_len` in NUM_PORTS*BLEN_W: packed read burst lengths
- `port_rd_data` out DATA_W: read data, broadcast to all ports
- `port_rd_ack` out NUM_PORTS: per-port read acknowledge, one-hot or zero
- `init_end` in 1: SDRAM initialisation complete
- `sdram_wr_req` out 1, `sdram_wr_addr` out ADDR_W, `wr_burst_len` out BLEN_W, `sdram_data_in` out DATA_W, `sdram_wr_ack` in 1: controller write port
- `sdram_rd_req` out 1, `sdram_rd_addr` out ADDR_W, `rd_burst_len` out BLEN_W, `sdram_data_out` in DATA_W, `sdram_rd_ack` in 1: controller read port
- `arb_err` out 1: sticky watchdog error flag
- `gnt_id` out clog2(NUM_PORTS), minimum 1 bit: index of the currently or last granted port

## Operation
- FSM states: IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST.
- **IDLE.** No grant is issued while `init_end`=0.
  - Otherwise the block scans ports `rr_ptr`, `rr_ptr+1`, … modulo NUM_PORTS. The first port with `wr_req|rd_req` wins.
  - Within a port, write has priority over read.
  - On a win: latch `gnt_id`, then go to WR_WAIT or RD_WAIT.
- **WR_WAIT / RD_WAIT.** The matching `sdram_*_req` is held at 1. The move to *_BURST happens when the matching `sdram_*_ack`=1.
- **\*_BURST.** Request is low. Ack is routed to `port_*_ack[gnt_id]`. When the ack returns to 0, go to IDLE and set `rr_ptr` = `gnt_id`+1, wrapping from NUM_PORTS-1 to 0.
- Address and length outputs are registered from the latched `gnt_id`. They are stable from the request cycle through the end of the burst.
- `sdram_data_in` = `port_wr_data[gnt_id]`, combinational. The controller samples it inside its ack window.
- `port_rd_data` = `sdram_data_out`, combinational. Only the port whose `port_rd_ack` is high consumes it.
- Port acks are combinational: `port_wr_ack[k]` = `sdram_wr_ack` & (state==WR_BURST or WR_WAIT) & (`gnt_id`==k). The same form applies to read.
- Once a port is granted, dropping its port request has no effect. The arbiter completes the handshake with the controller.
- Requests from non-granted ports are ignored until IDLE.

## Timing
- **Reset values:** all `sdram_*_req`, all `port_*_ack`, `arb_err`, `gnt_id` and `rr_ptr` are 0. Address, length and data registers are 0. State is IDLE.
- **Grant latency:** request seen in IDLE at cycle n gives `sdram_*_req`=1 at cycle n+1.
- **Ack to port:** zero-cycle, combinational.
- **Release:** ack falling at cycle m gives state IDLE at m+1. The earliest next `sdram_*_req` is at m+2 (one dead cycle).
- **Simultaneous write and read on one port:** write first. The read is served on that port's next turn in the rotation.
- **NUM_PORTS=1:** rotation degenerates and `rr_ptr` stays 0.
- **Reset mid-burst:** all outputs return to reset values immediately (asynchronous).

## Configuration
- Macro: `SDRAM_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WR_WAIT/RD_WAIT.
  - If it reaches TIMEOUT_CYC without an ack: drop the request, set `arb_err`=1, return to IDLE and advance `rr_ptr`.
  - `arb_err` clears only on reset.
- **Undefined:** no counter is built, `arb_err` is tied to 0, and a WAIT state holds indefinitely.

## Test plan
- **Write burst on port 2:** NUM_PORTS=4. `init_end`=1, `port_wr_req[2]`=1 with addr 0x00100, len 8. Expect `sdram_wr_addr`=0x00100, `wr_burst_len`=8, `gnt_id`=2. `port_wr_ack`=4'b0100 for exactly 8 cycles of controller ack.
- **Round-robin:** all four ports request writes continuously. Grant order is 0,1,2,3,0. There is one IDLE cycle between bursts.
- **Write before read on one port:** port 1 raises wr and rd in the same cycle. The write burst completes first. The read follows after the other pending ports have been served. `port_rd_data` equals `sdram_data_out` during `port_rd_ack[1]`.
- **Init gate:** requests with `init_end`=0 keep `sdram_wr_req`=`sdram_rd_req`=0. The first grant appears one cycle after `init_end` rises.
- **Reset mid-burst:** assert `sys_rst_n`=0 during RD_BURST. All outputs go to 0 and `gnt_id`=0. After release, a fresh request is granted normally.
- **Watchdog (`SDRAM_ARB_TIMEOUT_EN`, TIMEOUT_CYC=16):** never ack. `sdram_wr_req` drops after 16 cycles and `arb_err`=1 stays set. The next port is granted.

Source files
------------

// File: rtl/sdram_port_arbit.sv
// sdram_port_arbit: round-robin multi-port front end for the SDRAM controller; `SDRAM_ARB_TIMEOUT_EN adds a wait-state watchdog
module sdram_port_arbit #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32,
  parameter int BLEN_W = 9,
  parameter int TIMEOUT_CYC = 1024,
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [NUM_PORTS-1:0]        port_wr_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_wr_addr,
  input  logic [NUM_PORTS*BLEN_W-1:0] port_wr_len,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wr_data,
  output logic [NUM_PORTS-1:0]        port_wr_ack,
  input  logic [NUM_PORTS-1:0]        port_rd_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_rd_addr,
  input  logic [NUM_PORTS*BLEN_W-1:0] port_rd_len,
  output logic [DATA_W-1:0]           port_rd_data,
  output logic [NUM_PORTS-1:0]        port_rd_ack,
  input  logic                        init_end,
  output logic                        sdram_wr_req,
  output logic [ADDR_W-1:0]           sdram_wr_addr,
  output logic [BLEN_W-1:0]           wr_burst_len,
  output logic [DATA_W-1:0]           sdram_data_in,
  input  logic                        sdram_wr_ack,
  output logic                        sdram_rd_req,
  output logic [ADDR_W-1:0]           sdram_rd_addr,
  output logic [BLEN_W-1:0]           rd_burst_len,
  input  logic [DATA_W-1:0]           sdram_data_out,
  input  logic                        sdram_rd_ack,
  output logic                        arb_err,
  output logic [GW-1:0]               gnt_id
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_WAIT  = 3'd1;
  localparam logic [2:0] WR_BURST = 3'd2;
  localparam logic [2:0] RD_WAIT  = 3'd3;
  localparam logic [2:0] RD_BURST = 3'd4;

  logic [2:0] state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] win;
  logic [GW-1:0] gnt_nxt;
  logic hit;
  logic hit_wr;
  logic wr_act;
  logic rd_act;
  logic tmo;

  logic [ADDR_W-1:0] wa [NUM_PORTS];
  logic [ADDR_W-1:0] ra [NUM_PORTS];
  logic [BLEN_W-1:0] wl [NUM_PORTS];
  logic [BLEN_W-1:0] rl [NUM_PORTS];
  logic [DATA_W-1:0] wd [NUM_PORTS];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign wa[k] = port_wr_addr[k*ADDR_W +: ADDR_W];
    assign ra[k] = port_rd_addr[k*ADDR_W +: ADDR_W];
    assign wl[k] = port_wr_len[k*BLEN_W +: BLEN_W];
    assign rl[k] = port_rd_len[k*BLEN_W +: BLEN_W];
    assign wd[k] = port_wr_data[k*DATA_W +: DATA_W];
    assign port_wr_ack[k] = sdram_wr_ack & wr_act & (gnt_id == GW'(k));
    assign port_rd_ack[k] = sdram_rd_ack & rd_act & (gnt_id == GW'(k));
  end

  assign wr_act        = (state == WR_WAIT) || (state == WR_BURST);
  assign rd_act        = (state == RD_WAIT) || (state == RD_BURST);
  assign sdram_wr_req  = state == WR_WAIT;
  assign sdram_rd_req  = state == RD_WAIT;
  assign sdram_data_in = wd[gnt_id];
  assign port_rd_data  = sdram_data_out;
  assign gnt_nxt       = (gnt_id == GW'(NUM_PORTS - 1)) ? '0 : gnt_id + GW'(1);

  // Scan from rr_ptr upward (mod NUM_PORTS); first port with any request wins, write before read.
  always_comb begin : scan
    int j;
    j = 0;
    hit = 1'b0;
    hit_wr = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!hit && (port_wr_req[j] | port_rd_req[j])) begin
        hit = 1'b1;
        hit_wr = port_wr_req[j];
        win = GW'(j);
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wdg_cnt;
  logic err_q;
  logic wait_st;
  logic cur_ack;
  assign wait_st = (state == WR_WAIT) || (state == RD_WAIT);
  assign cur_ack = (state == WR_WAIT) ? sdram_wr_ack : sdram_rd_ack;
  assign tmo     = wait_st && !cur_ack && (wdg_cnt == CW'(TIMEOUT_CYC - 1));
  assign arb_err = err_q;

  // Count unanswered wait cycles; the error flag is sticky until reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wdg_cnt <= '0;
      err_q <= 1'b0;
    end else begin
      wdg_cnt <= (wait_st && !cur_ack && !tmo) ? wdg_cnt + CW'(1) : '0;
      err_q <= err_q | tmo;
    end
`else
  assign tmo     = TIMEOUT_CYC < 0;
  assign arb_err = 1'b0;
`endif

  // Grant FSM: address/length are captured once at grant and held through the burst.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      gnt_id <= '0;
      rr_ptr <= '0;
      sdram_wr_addr <= '0;
      wr_burst_len <= '0;
      sdram_rd_addr <= '0;
      rd_burst_len <= '0;
    end else begin
      case (state)
        IDLE:
          if (init_end && hit) begin
            gnt_id <= win;
            if (hit_wr) begin
              state <= WR_WAIT;
              sdram_wr_addr <= wa[win];
              wr_burst_len <= wl[win];
            end else begin
              state <= RD_WAIT;
              sdram_rd_addr <= ra[win];
              rd_burst_len <= rl[win];
            end
          end
        WR_WAIT:
          if (sdram_wr_ack) state <= WR_BURST;
          else if (tmo) begin
            state <= IDLE;
            rr_ptr <= gnt_nxt;
          end
        WR_BURST:
          if (!sdram_wr_ack) begin
            state <= IDLE;
            rr_ptr <= gnt_nxt;
          end
        RD_WAIT:
          if (sdram_rd_ack) state <= RD_BURST;
          else if (tmo) begin
            state <= IDLE;
            rr_ptr <= gnt_nxt;
          end
        RD_BURST:
          if (!sdram_rd_ack) begin
            state <= IDLE;
            rr_ptr <= gnt_nxt;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_port_arbit.sv
// tb_sdram_port_arbit: directed scenarios plus randomized traffic against a transaction-level arbiter model
module tb_sdram_port_arbit;
  localparam int NP = 4;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam int BW = 9;
  localparam int TO = 16;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0] wr_req = '0, rd_req = '0, wr_ack_p, rd_ack_p;
  logic [NP*AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [NP*BW-1:0] wr_len = '0, rd_len = '0;
  logic [NP*DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data_p;
  logic init_end = 1'b0;
  logic s_wr_req, s_rd_req, s_wr_ack, s_rd_ack;
  logic [AW-1:0] s_wr_addr, s_rd_addr;
  logic [BW-1:0] s_wr_len, s_rd_len;
  logic [DW-1:0] s_din, s_dout;
  logic arb_err;
  logic [GW-1:0] gnt_id;

  sdram_port_arbit #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BLEN_W(BW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .port_wr_req(wr_req), .port_wr_addr(wr_addr), .port_wr_len(wr_len), .port_wr_data(wr_data), .port_wr_ack(wr_ack_p),
    .port_rd_req(rd_req), .port_rd_addr(rd_addr), .port_rd_len(rd_len), .port_rd_data(rd_data_p), .port_rd_ack(rd_ack_p),
    .init_end(init_end),
    .sdram_wr_req(s_wr_req), .sdram_wr_addr(s_wr_addr), .wr_burst_len(s_wr_len), .sdram_data_in(s_din), .sdram_wr_ack(s_wr_ack),
    .sdram_rd_req(s_rd_req), .sdram_rd_addr(s_rd_addr), .rd_burst_len(s_rd_len), .sdram_data_out(s_dout), .sdram_rd_ack(s_rd_ack),
    .arb_err(arb_err), .gnt_id(gnt_id)
  );

  int checks = 0;
  int fails = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding grant (port, direction, acked?), rotating start pointer.
  bit m_busy = 0, m_wr = 0, m_acked = 0, m_err = 0;
  int m_port = 0, m_rr = 0, m_gnt = 0, m_cnt = 0;
  logic [AW-1:0] m_waddr = '0, m_raddr = '0;
  logic [BW-1:0] m_wlen = '0, m_rlen = '0;

  task automatic model_step();
    bit a;
    if (!rst_n) begin
      m_busy = 0; m_wr = 0; m_acked = 0; m_err = 0;
      m_port = 0; m_rr = 0; m_gnt = 0; m_cnt = 0;
      m_waddr = '0; m_raddr = '0; m_wlen = '0; m_rlen = '0;
      return;
    end
    if (!m_busy) begin
      if (init_end)
        for (int i = 0; i < NP; i++) begin
          int p;
          p = (m_rr + i) % NP;
          if (wr_req[p] | rd_req[p]) begin
            m_busy = 1; m_port = p; m_gnt = p; m_wr = wr_req[p]; m_acked = 0; m_cnt = 0;
            if (m_wr) begin
              m_waddr = wr_addr[p*AW +: AW];
              m_wlen = wr_len[p*BW +: BW];
            end else begin
              m_raddr = rd_addr[p*AW +: AW];
              m_rlen = rd_len[p*BW +: BW];
            end
            break;
          end
        end
    end else begin
      a = m_wr ? s_wr_ack : s_rd_ack;
      if (!m_acked) begin
        if (a) m_acked = 1;
        else begin
          m_cnt++;
`ifdef SDRAM_ARB_TIMEOUT_EN
          if (m_cnt == TO) begin
            m_busy = 0; m_err = 1; m_rr = (m_port + 1) % NP;
          end
`endif
        end
      end else if (!a) begin
        m_busy = 0;
        m_rr = (m_port + 1) % NP;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every cycle, compare DUT outputs with the model (reset forces everything to zero).
  initial forever begin
    logic [NP-1:0] ew, er;
    int g;
    @(negedge clk);
    ew = '0;
    er = '0;
    if (rst_n && m_busy && m_wr && s_wr_ack) ew[m_port] = 1'b1;
    if (rst_n && m_busy && !m_wr && s_rd_ack) er[m_port] = 1'b1;
    g = rst_n ? m_gnt : 0;
    chk("wr_req", 64'(s_wr_req), 64'(rst_n && m_busy && m_wr && !m_acked));
    chk("rd_req", 64'(s_rd_req), 64'(rst_n && m_busy && !m_wr && !m_acked));
    chk("port_wr_ack", 64'(wr_ack_p), 64'(ew));
    chk("port_rd_ack", 64'(rd_ack_p), 64'(er));
    chk("gnt_id", 64'(gnt_id), 64'(g));
    chk("wr_addr", 64'(s_wr_addr), rst_n ? 64'(m_waddr) : 64'd0);
    chk("wr_len", 64'(s_wr_len), rst_n ? 64'(m_wlen) : 64'd0);
    chk("rd_addr", 64'(s_rd_addr), rst_n ? 64'(m_raddr) : 64'd0);
    chk("rd_len", 64'(s_rd_len), rst_n ? 64'(m_rlen) : 64'd0);
    chk("arb_err", 64'(arb_err), 64'(rst_n && m_err));
    chk("data_in", 64'(s_din), 64'(wr_data[g*DW +: DW]));
    chk("rd_data", 64'(rd_data_p), 64'(s_dout));
  end

  // Controller emulation: answer each request after 0..dly_max cycles with an ack lasting burst_len cycles.
  bit mute = 0;
  int dly_max = 0;
  int wrem = 0, rrem = 0, wdly = -1, rdly = -1;
  initial begin
    s_wr_ack = 1'b0;
    s_rd_ack = 1'b0;
    s_dout = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        s_wr_ack = 1'b0; s_rd_ack = 1'b0; wrem = 0; rrem = 0; wdly = -1; rdly = -1;
      end else begin
        if (s_wr_ack) begin
          wrem--;
          if (wrem == 0) s_wr_ack = 1'b0;
        end else begin
          if (wdly < 0 && s_wr_req && !mute) wdly = int'($urandom_range(dly_max, 0));
          if (wdly == 0) begin
            s_wr_ack = 1'b1; wrem = (s_wr_len == 0) ? 1 : int'(s_wr_len); wdly = -1;
          end else if (wdly > 0) wdly--;
        end
        if (s_rd_ack) begin
          rrem--;
          if (rrem == 0) s_rd_ack = 1'b0;
        end else begin
          if (rdly < 0 && s_rd_req && !mute) rdly = int'($urandom_range(dly_max, 0));
          if (rdly == 0) begin
            s_rd_ack = 1'b1; rrem = (s_rd_len == 0) ? 1 : int'(s_rd_len); rdly = -1;
          end else if (rdly > 0) rdly--;
        end
      end
      s_dout = $urandom;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_req(string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_wr_req | s_rd_req;
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  initial begin
    int n8, oth, nrd1, n0, cyc, last_ack;
    bit prev, found, g1;
    int order[$];
    int seq[$];
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_seq[4] = '{3, 5, 6, 2};

    repeat (2) @(negedge clk);
    chk("reset_gnt", 64'(gnt_id), 64'd0);
    chk("reset_wr_req", 64'(s_wr_req), 64'd0);
    chk("reset_err", 64'(arb_err), 64'd0);
    tick();
    rst_n = 1'b1;

    // init gate
    wr_req[0] = 1'b1; wr_addr[0 +: AW] = 21'h12345; wr_len[0 +: BW] = 9'd3;
    repeat (4) begin
      @(negedge clk);
      chk("gate_wr_req", 64'(s_wr_req), 64'd0);
      chk("gate_rd_req", 64'(s_rd_req), 64'd0);
    end
    tick();
    init_end = 1'b1;
    @(negedge clk);
    chk("gate_same_cycle", 64'(s_wr_req), 64'd0);
    @(negedge clk);
    chk("gate_first_grant", 64'(s_wr_req), 64'd1);
    chk("gate_addr", 64'(s_wr_addr), 64'h12345);
    tick();
    wr_req = '0;
    repeat (12) tick();

    // write burst on port 2
    wr_req[2] = 1'b1; wr_addr[2*AW +: AW] = 21'h00100; wr_len[2*BW +: BW] = 9'd8;
    wait_req("wr2_granted");
    chk("wr2_gnt", 64'(gnt_id), 64'd2);
    chk("wr2_addr", 64'(s_wr_addr), 64'h100);
    chk("wr2_len", 64'(s_wr_len), 64'd8);
    n8 = (wr_ack_p == 4'b0100) ? 1 : 0;
    oth = 0;
    tick();
    wr_req = '0;
    repeat (20) begin
      @(negedge clk);
      if (wr_ack_p == 4'b0100) n8++;
      else if (wr_ack_p != '0) oth++;
    end
    chk("wr2_ack_cycles", 64'(n8), 64'd8);
    chk("wr2_ack_other", 64'(oth), 64'd0);

    // round-robin with continuous requests
    do_reset();
    for (int k = 0; k < NP; k++) begin
      wr_len[k*BW +: BW] = 9'd2;
      wr_addr[k*AW +: AW] = AW'(k * 16);
    end
    wr_req = '1;
    prev = 0; cyc = 0; last_ack = -100;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      @(negedge clk);
      cyc++;
      if (s_wr_req && !prev) begin
        order.push_back(int'(gnt_id));
        if (order.size() > 1) chk("rr_gap", 64'(cyc - last_ack), 64'd3);
      end
      if (wr_ack_p != '0) last_ack = cyc;
      prev = s_wr_req;
    end
    chk("rr_count", 64'(order.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(order.size() > i ? order[i] : -1), 64'(exp_rr[i]));
    tick();
    wr_req = '0;
    repeat (12) tick();

    // write before read on one port
    do_reset();
    wr_len[1*BW +: BW] = 9'd3; wr_len[2*BW +: BW] = 9'd2;
    rd_len[1*BW +: BW] = 9'd4; rd_len[3*BW +: BW] = 9'd2;
    wr_req = 4'b0110;
    rd_req = 4'b1010;
    prev = 0; nrd1 = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if ((s_wr_req | s_rd_req) && !prev) begin
        seq.push_back(int'(gnt_id) * 2 + (s_wr_req ? 1 : 0));
        if (s_wr_req) wr_req[gnt_id] = 1'b0;
        else rd_req[gnt_id] = 1'b0;
      end
      prev = s_wr_req | s_rd_req;
      if (rd_ack_p == 4'b0010) begin
        nrd1++;
        chk("rd1_data", 64'(rd_data_p), 64'(s_dout));
      end
    end
    chk("wbr_count", 64'(seq.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("wbr_order", 64'(seq.size() > i ? seq[i] : -1), 64'(exp_seq[i]));
    chk("rd1_ack_cycles", 64'(nrd1), 64'd4);

    // reset mid read burst
    rd_req[3] = 1'b1; rd_addr[3*AW +: AW] = 21'h1ABCD; rd_len[3*BW +: BW] = 9'd6;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = rd_ack_p[3] && !s_rd_req;
    end
    chk("rst_burst_reached", 64'(found), 64'd1);
    rd_req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_req", 64'(s_rd_req), 64'd0);
    chk("rst_rd_ack", 64'(rd_ack_p), 64'd0);
    chk("rst_gnt", 64'(gnt_id), 64'd0);
    chk("rst_rd_addr", 64'(s_rd_addr), 64'd0);
    chk("rst_rd_len", 64'(s_rd_len), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    wr_req[1] = 1'b1; wr_addr[1*AW +: AW] = 21'h00777; wr_len[1*BW +: BW] = 9'd2;
    wait_req("post_rst_granted");
    chk("post_rst_gnt", 64'(gnt_id), 64'd1);
    chk("post_rst_addr", 64'(s_wr_addr), 64'h777);
    tick();
    wr_req = '0;
    repeat (12) tick();

`ifdef SDRAM_ARB_TIMEOUT_EN
    // watchdog: no ack ever, request drops after TO cycles and the next port is served
    do_reset();
    mute = 1;
    wr_req = 4'b0011;
    n0 = 0; g1 = 0;
    for (int c = 0; c < 60 && !g1; c++) begin
      @(negedge clk);
      if (s_wr_req && gnt_id == 0) n0++;
      if (s_wr_req && gnt_id == 1) g1 = 1;
    end
    mute = 0;
    wr_req = '0;
    chk("wdg_req_cycles", 64'(n0), 64'd16);
    chk("wdg_next_port", 64'(g1), 64'd1);
    chk("wdg_err", 64'(arb_err), 64'd1);
    repeat (15) tick();
    chk("wdg_err_sticky", 64'(arb_err), 64'd1);
`endif

    // randomized traffic
    dly_max = 3;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(3, 0) == 0) wr_req = NP'($urandom);
      if ($urandom_range(3, 0) == 0) rd_req = NP'($urandom);
      for (int k = 0; k < NP; k++) begin
        wr_addr[k*AW +: AW] = AW'($urandom);
        rd_addr[k*AW +: AW] = AW'($urandom);
        wr_len[k*BW +: BW] = BW'($urandom_range(6, 0));
        rd_len[k*BW +: BW] = BW'($urandom_range(6, 0));
        wr_data[k*DW +: DW] = $urandom;
      end
      init_end = ($urandom_range(19, 0) != 0);
      if (c == 1000 || c == 2000) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    wr_req = '0;
    rd_req = '0;
    repeat (20) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
